fcs_append: RTL

- Transmit-side companion to the RMII frame checksum checker.
- Takes a contiguous dibit stream of frame bytes (destination MAC through payload, no FCS) and forwards it with one cycle of latency.
- When the stream ends, appends the 4-byte Ethernet FCS as 16 dibits, then enforces an inter-frame gap.
- Sits between the frame assembler and the RMII TX pins. Its output, fed into the checker, yields done=1, kill=0.

---
 rtl/fcs_append_if.sv | 14 +
 rtl/fcs_append.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fcs_append_if.sv
// Dibit stream bundle for fcs_append: input stream (axiiv/axiid) from the
// frame assembler, output stream (axiov/axiod) to the RMII TX pins, plus
// busy/drop status back to the assembler.
interface fcs_append_if;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;
  logic       busy;
  logic       drop;

  modport master (output axiiv, axiid, input axiov, axiod, busy, drop);
  modport slave  (input axiiv, axiid, output axiov, axiod, busy, drop);
endinterface

// File: rtl/fcs_append.sv
// fcs_append: forwards a contiguous dibit frame with one cycle of latency,
// appends the 32-bit Ethernet FCS as 16 dibits, then holds an inter-frame gap.
// Ports: clk, rst (async, active low), bus (fcs_append_if.slave: axiiv/axiid
// in, axiov/axiod out, busy, drop).
// Optional macro FCS_APPEND_PAD_EN: zero-pad short frames to MIN_DIBITS.
module fcs_append #(
  parameter int unsigned IFG_DIBITS = 48,
  parameter int unsigned MIN_DIBITS = 240
) (
  input  logic       clk,
  input  logic       rst,
  fcs_append_if.slave bus
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam int unsigned CNT_MAX =
    (MIN_DIBITS > IFG_DIBITS) ? ((MIN_DIBITS > 16) ? MIN_DIBITS : 16)
                              : ((IFG_DIBITS > 16) ? IFG_DIBITS : 16);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_DIBITS);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_DIBITS - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ARMED,
    IDLE,
    DATA,
`ifdef FCS_APPEND_PAD_EN
    PAD,
`endif
    FCS,
    IFG
  } state_t;

  state_t           state, state_n;
  logic [31:0]      crc, crc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] cnt_sat;
  logic [1:0]       fcs_dibit;
  logic             ov_n;
  logic [1:0]       od_n;
  logic             drop_n;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    crc_dibit = crc_step(crc_step(c, d[0]), d[1]);
  endfunction

  // One counter serves the data-length count, the FCS dibit index and the
  // IFG count; it is cleared on every entry to IDLE via IFG or reset.
  assign cnt_sat   = (cnt < MIN_CNT) ? cnt + CNT_ONE : cnt;
  // FCS goes out from the top of the inverted register; the register is
  // shifted by two per FCS dibit rather than indexed.
  assign fcs_dibit = {~crc[30], ~crc[31]};

  always_comb begin
    state_n = state;
    crc_n   = crc;
    cnt_n   = cnt;
    ov_n    = 1'b0;
    od_n    = 2'b00;
    drop_n  = 1'b0;
    unique case (state)
      ARMED: begin
        if (bus.axiiv) drop_n  = 1'b1;
        else           state_n = IDLE;
      end
      IDLE: begin
        if (bus.axiiv) begin
          ov_n    = 1'b1;
          od_n    = bus.axiid;
          crc_n   = crc_dibit(crc, bus.axiid);
          cnt_n   = cnt_sat;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bus.axiiv) begin
          ov_n  = 1'b1;
          od_n  = bus.axiid;
          crc_n = crc_dibit(crc, bus.axiid);
          cnt_n = cnt_sat;
        end
`ifdef FCS_APPEND_PAD_EN
        else if (cnt < MIN_CNT) begin
          ov_n    = 1'b1;
          crc_n   = crc_dibit(crc, 2'b00);
          cnt_n   = cnt + CNT_ONE;
          state_n = PAD;
        end
`endif
        else begin
          ov_n    = 1'b1;
          od_n    = fcs_dibit;
          crc_n   = {crc[29:0], 2'b00};
          cnt_n   = CNT_ONE;
          state_n = FCS;
        end
      end
`ifdef FCS_APPEND_PAD_EN
      PAD: begin
        drop_n = bus.axiiv;
        ov_n   = 1'b1;
        if (cnt < MIN_CNT) begin
          crc_n = crc_dibit(crc, 2'b00);
          cnt_n = cnt + CNT_ONE;
        end else begin
          od_n    = fcs_dibit;
          crc_n   = {crc[29:0], 2'b00};
          cnt_n   = CNT_ONE;
          state_n = FCS;
        end
      end
`endif
      FCS: begin
        drop_n = bus.axiiv;
        ov_n   = 1'b1;
        od_n   = fcs_dibit;
        if (cnt == FCS_LAST) begin
          crc_n   = '1;
          cnt_n   = '0;
          state_n = IFG;
        end else begin
          crc_n = {crc[29:0], 2'b00};
          cnt_n = cnt + CNT_ONE;
        end
      end
      IFG: begin
        drop_n = bus.axiiv;
        if (cnt == IFG_LAST) begin
          cnt_n   = '0;
          // A frame already running at gap end must first be seen low.
          state_n = bus.axiiv ? ARMED : IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = ARMED;
    endcase
  end

  always_comb begin
    bus.busy = (state == FCS) || (state == IFG);
`ifdef FCS_APPEND_PAD_EN
    if (state == PAD) bus.busy = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARMED;
      crc       <= '1;
      cnt       <= '0;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
      bus.drop  <= 1'b0;
    end else begin
      state     <= state_n;
      crc       <= crc_n;
      cnt       <= cnt_n;
      bus.axiov <= ov_n;
      bus.axiod <= od_n;
      bus.drop  <= drop_n;
    end
  end

endmodule
